uart_cmd_loader: RTL and testbench

//  Packet controller that sequences the UART receiver. It paces byte intake through the receiver's uart_ready.
//  It parses framed host packets and streams WRITE payloads as words into the array buffer write port.

---
 rtl/uart_cmd_pkg.sv | 15 +
 rtl/uart_word_packer.sv | 33 +++
 rtl/uart_cmd_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command loader.
package uart_cmd_pkg;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, CMD_OUT, DRAIN} state_t;

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_CTRL_MIN = 8'h02;
    localparam logic [7:0] OP_CTRL_MAX = 8'h7F;
    localparam int         HDR_BYTES   = 4;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_WRITE) || (op >= OP_CTRL_MIN && op <= OP_CTRL_MAX);
    endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first and flags the byte that completes a word.
module uart_word_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    shift,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_full
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    // Word as it looks with the incoming byte appended, so the top can load it in the same cycle.
    assign word      = W'({sr, byte_in});
    assign word_full = shift && (cnt == CW'(WORD_BYTES - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= word;
            cnt <= word_full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_loader.sv
// Parses framed host packets from the UART receiver into write-port words or scheduler commands.
module uart_cmd_loader
    import uart_cmd_pkg::*;
#(
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              cmd_opcode,
    output logic [ADDR_WIDTH-1:0]   cmd_addr,
    output logic [15:0]             cmd_len,
    output logic                    pkt_done,
    output logic                    pkt_err,
    output logic                    busy
);
    localparam int DW = 8 * WORD_BYTES;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    state_t                state, state_n;
    logic                  rx_valid_q, byte_stb;
    logic [7:0]            op, csum;
    logic [31:0]           hdr, hdr_next;
    logic [2:0]            hdr_cnt;
    logic                  hdr_last;
    logic [15:0]           words_left;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [TW-1:0]         timer;
    logic                  timeout;
    logic [DW-1:0]         word;
    logic                  word_full, load;

    assign byte_stb   = rx_valid & ~rx_valid_q;
    assign hdr_next   = {hdr[23:0], rx_data};
    assign hdr_last   = byte_stb && state == HDR && hdr_cnt == 3'(HDR_BYTES - 1);
    assign load       = word_full && state == PAYLOAD;
    assign timeout    = (timer == TW'(IDLE_TIMEOUT)) && !byte_stb;

    assign rx_ready   = ~(wr_valid & ~wr_ready) & (state != CMD_OUT);
    assign busy       = state != IDLE;
    assign cmd_opcode = op;
    assign cmd_addr   = hdr[16 +: ADDR_WIDTH];
    assign cmd_len    = hdr[15:0];

    uart_word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == IDLE),
        .shift     (byte_stb && state == PAYLOAD),
        .byte_in   (rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rx_valid_q <= 1'b0;
            op         <= '0;
            csum       <= '0;
            hdr        <= '0;
            hdr_cnt    <= '0;
            words_left <= '0;
            word_addr  <= '0;
            timer      <= '0;
        end else begin
            state      <= state_n;
            rx_valid_q <= rx_valid;
            if (state == IDLE)
                hdr_cnt <= '0;
            else if (byte_stb && state == HDR)
                hdr_cnt <= hdr_cnt + 3'd1;
            if (byte_stb && state == IDLE) begin
                op   <= rx_data;
                csum <= rx_data;
            end else if (byte_stb && (state == HDR || state == PAYLOAD)) begin
                csum <= csum ^ rx_data;
            end
            if (byte_stb && state == HDR)
                hdr <= hdr_next;
            if (hdr_last) begin
                words_left <= hdr_next[15:0];
                word_addr  <= hdr_next[16 +: ADDR_WIDTH];
            end else if (load) begin
                words_left <= words_left - 16'd1;
                word_addr  <= word_addr + ADDR_WIDTH'(1);
            end
            // Frozen while the receiver is held off so a stalled write never looks like a dead link.
            if (byte_stb || state == IDLE || state == CMD_OUT)
                timer <= '0;
            else if (rx_ready && timer != TW'(IDLE_TIMEOUT))
                timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_data  <= word;
            wr_addr  <= word_addr;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    always_comb begin
        state_n   = state;
        pkt_done  = 1'b0;
        pkt_err   = 1'b0;
        cmd_valid = 1'b0;
        case (state)
            IDLE: if (byte_stb) begin
                if (op_valid(rx_data)) begin
                    state_n = HDR;
                end else begin
                    state_n = DRAIN;
                    pkt_err = 1'b1;
                end
            end
            HDR: if (hdr_last) begin
                state_n = (op == OP_WRITE && hdr_next[15:0] != 16'd0) ? PAYLOAD : CSUM;
            end else if (timeout) begin
                state_n = IDLE;
                pkt_err = 1'b1;
            end
            PAYLOAD: if (load && words_left == 16'd1) begin
                state_n = CSUM;
            end else if (timeout) begin
                state_n = IDLE;
                pkt_err = 1'b1;
            end
            CSUM: if (byte_stb) begin
                if (rx_data != csum) begin
                    state_n = IDLE;
                    pkt_err = 1'b1;
                end else if (op == OP_WRITE) begin
                    state_n  = IDLE;
                    pkt_done = 1'b1;
                end else begin
                    state_n = CMD_OUT;
                end
            end else if (timeout) begin
                state_n = IDLE;
                pkt_err = 1'b1;
            end
            CMD_OUT: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_n  = IDLE;
                    pkt_done = 1'b1;
                end
            end
            DRAIN: if (timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader: writes, stalls, control commands, faults and reset.
module tb_uart_cmd_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        pkt_done, pkt_err, busy;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_err = 0, n_words = 0, n_cmd = 0, n_cmdv = 0;
    logic [31:0] wdata[$];
    logic [15:0] waddr[$];
    logic [7:0]  last_op;
    logic [15:0] last_addr, last_len;
    logic [7:0]  csum_acc;

    uart_cmd_loader #(.WORD_BYTES(4), .ADDR_WIDTH(16), .IDLE_TIMEOUT(2000)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Inputs change at posedge+1, so values seen here are what the next posedge acts on.
    always @(negedge clock) begin
        if (pkt_done) n_done++;
        if (pkt_err) n_err++;
        if (cmd_valid) n_cmdv++;
        if (wr_valid && wr_ready) begin
            wdata.push_back(wr_data);
            waddr.push_back(wr_addr);
            n_words++;
        end
        if (cmd_valid && cmd_ready) begin
            n_cmd++;
            last_op = cmd_opcode;
            last_addr = cmd_addr;
            last_len = cmd_len;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        while (!rx_ready && k < 20000) begin
            tick(1);
            k++;
        end
        chk("rx_ready_wait", rx_ready, 1'b1);
        csum_acc = csum_acc ^ b;
        rx_data  = b;
        rx_valid = 1'b1;
        tick(4);
        rx_valid = 1'b0;
        tick(3);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] a, input logic [15:0] l);
        csum_acc = 8'h00;
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(l[15:8]);
        send_byte(l[7:0]);
    endtask

    task automatic send_csum(input logic [7:0] flip);
        send_byte(csum_acc ^ flip);
    endtask

    initial begin
        int base, d0, e0, c0, v0, bad, viol, vcyc;

        // reset state
        tick(3);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {pkt_done, pkt_err}, 2'b00);
        reset = 1'b0;
        tick(2);

        // basic WRITE of two words
        d0 = n_done; e0 = n_err; base = n_words;
        send_hdr(8'h01, 16'h0010, 16'h0002);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_csum(8'h00);
        tick(5);
        chk("w1_count", n_words, base + 2);
        chk("w1_data0", wdata[base], 32'h01020304);
        chk("w1_addr0", waddr[base], 16'h0010);
        chk("w1_data1", wdata[base+1], 32'h05060708);
        chk("w1_addr1", waddr[base+1], 16'h0011);
        chk("w1_done", n_done, d0 + 1);
        chk("w1_err", n_err, e0);
        chk("w1_idle", busy, 1'b0);

        // same packet with the write port stalled after the first word
        d0 = n_done; e0 = n_err; base = n_words; viol = 0; vcyc = 0;
        fork
            begin
                send_hdr(8'h01, 16'h0010, 16'h0002);
                for (int i = 1; i <= 8; i++) send_byte(8'(i));
                send_csum(8'h00);
            end
            begin
                int k = 0;
                while (n_words != base + 1 && k < 1000) begin
                    tick(1);
                    k++;
                end
                wr_ready = 1'b0;
                repeat (5000) begin
                    tick(1);
                    if (wr_valid && rx_ready) viol++;
                    if (wr_valid) vcyc++;
                end
                wr_ready = 1'b1;
            end
        join
        tick(5);
        chk("stall_rx_ready_low", viol, 0);
        chk("stall_seen", vcyc > 4000, 1'b1);
        chk("stall_count", n_words, base + 2);
        chk("stall_data1", wdata[base+1], 32'h05060708);
        chk("stall_addr1", waddr[base+1], 16'h0011);
        chk("stall_err", n_err, e0);
        chk("stall_done", n_done, d0 + 1);

        // control command held until the scheduler accepts
        d0 = n_done; c0 = n_cmd; bad = 0;
        cmd_ready = 1'b0;
        send_hdr(8'h02, 16'h0003, 16'h0100);
        send_csum(8'h00);
        repeat (10) begin
            tick(1);
            if (!cmd_valid || cmd_opcode != 8'h02 || cmd_addr != 16'h0003 ||
                cmd_len != 16'h0100 || rx_ready) bad++;
        end
        chk("cmd_stable", bad, 0);
        chk("cmd_no_done_yet", n_done, d0);
        cmd_ready = 1'b1;
        @(negedge clock);
        chk("cmd_done_pulse", pkt_done, 1'b1);
        tick(1);
        chk("cmd_valid_drop", cmd_valid, 1'b0);
        chk("cmd_count", n_cmd, c0 + 1);
        chk("cmd_done", n_done, d0 + 1);

        // control packet with a corrupted checksum, then a good one
        e0 = n_err; v0 = n_cmdv; d0 = n_done; c0 = n_cmd;
        send_hdr(8'h05, 16'h1234, 16'h0007);
        send_csum(8'h01);
        tick(5);
        chk("badcs_err", n_err, e0 + 1);
        chk("badcs_no_cmd", n_cmdv, v0);
        chk("badcs_no_done", n_done, d0);
        send_hdr(8'h7F, 16'hABCD, 16'h0042);
        send_csum(8'h00);
        tick(5);
        chk("good_cmd_count", n_cmd, c0 + 1);
        chk("good_cmd_fields", {last_op, last_addr, last_len}, {8'h7F, 16'hABCD, 16'h0042});
        chk("good_cmd_done", n_done, d0 + 1);

        // invalid opcode drains junk, errors once, and recovers after the idle gap
        e0 = n_err; d0 = n_done; base = n_words;
        send_byte(8'h90);
        send_byte(8'h01); send_byte(8'h05); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h7E); send_byte(8'h12);
        chk("drain_busy", busy, 1'b1);
        tick(2500);
        chk("drain_err_once", n_err, e0 + 1);
        chk("drain_idle", busy, 1'b0);
        send_hdr(8'h01, 16'h0020, 16'h0001);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_csum(8'h00);
        tick(5);
        chk("post_drain_data", wdata[base], 32'hAABBCCDD);
        chk("post_drain_addr", waddr[base], 16'h0020);
        chk("post_drain_done", n_done, d0 + 1);
        chk("post_drain_err", n_err, e0 + 1);

        // address wraps past the top of the space
        base = n_words;
        send_hdr(8'h01, 16'hFFFF, 16'h0002);
        for (int i = 8'h11; i <= 8'h18; i++) send_byte(8'(i));
        send_csum(8'h00);
        tick(5);
        chk("wrap_addr0", waddr[base], 16'hFFFF);
        chk("wrap_addr1", waddr[base+1], 16'h0000);
        chk("wrap_data1", wdata[base+1], 32'h15161718);

        // reset in the middle of a payload leaves a partial word behind
        e0 = n_err; d0 = n_done;
        send_hdr(8'h01, 16'h0030, 16'h0003);
        for (int i = 1; i <= 6; i++) send_byte(8'(8'h30 + i));
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("rst2_rx_ready", rx_ready, 1'b1);
        chk("rst2_outs", {wr_valid, cmd_valid, busy, pkt_done, pkt_err}, 5'b0);
        chk("rst2_wr", {wr_addr, wr_data}, 48'h0);
        reset = 1'b0;
        tick(2);
        base = n_words;
        send_hdr(8'h01, 16'h0040, 16'h0001);
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
        send_csum(8'h00);
        tick(5);
        chk("post_rst_data", wdata[base], 32'h21222324);
        chk("post_rst_addr", waddr[base], 16'h0040);
        chk("post_rst_done", n_done, d0 + 1);
        chk("post_rst_err", n_err, e0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
